// File: rtl/adder_arbiter_if.sv
// Requester-side bundle of adder_arbiter: packed operand lanes plus the
// request (stb/ack) and response (stb/ack) handshakes.
interface adder_arbiter_if #(
  parameter int N = 4
);
  logic [N*32-1:0] req_a;
  logic [N*32-1:0] req_b;
  logic [N-1:0]    req_stb;
  logic [N-1:0]    req_ack;
  logic [31:0]     rsp_z;
  logic [N-1:0]    rsp_stb;
  logic [N-1:0]    rsp_ack;

  modport master (
    output req_a, req_b, req_stb, rsp_ack,
    input  req_ack, rsp_z, rsp_stb
  );

  modport slave (
    input  req_a, req_b, req_stb, rsp_ack,
    output req_ack, rsp_z, rsp_stb
  );
endinterface

// File: rtl/adder_arbiter.sv
// Round-robin sharer of one single-precision adder among N requesters:
// grant one operand pair, strobe the adder, return the sum to its owner.
module adder_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic            clk,
  input  logic            rst,
  adder_arbiter_if.slave  req_if,
  output logic [31:0]     add_a_o,
  output logic [31:0]     add_b_o,
  output logic            add_a_stb_o,
  output logic            add_b_stb_o,
  input  logic [31:0]     add_z_i,
  input  logic            add_z_stb_i,
  output logic            add_z_ack_o,
  output logic            busy_o,
  output logic [IW-1:0]   grant_o,
  output logic [15:0]     op_count_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IW-1:0] grant_q, grant_d;
  logic [31:0]   add_a_q, add_a_d;
  logic [31:0]   add_b_q, add_b_d;
  logic          add_stb_q, add_stb_d;
  logic          add_z_ack_q, add_z_ack_d;
  logic [N-1:0]  req_ack_q, req_ack_d;
  logic [31:0]   rsp_z_q, rsp_z_d;
  logic [N-1:0]  rsp_stb_q, rsp_stb_d;
  logic          busy_q, busy_d;
  logic [15:0]   op_count_q, op_count_d;
  logic          op_done;

  logic [31:0]   lane_a [N];
  logic [31:0]   lane_b [N];
  logic          pick_valid;
  logic [IW-1:0] pick_idx;
  logic [IW-1:0] cand;

  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    assign lane_a[gi] = req_if.req_a[32*gi +: 32];
    assign lane_b[gi] = req_if.req_b[32*gi +: 32];
  end

  // First pending requester at or after rr_ptr, wrapping modulo N.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int i = 0; i < N; i++) begin
      cand = IW'((int'(rr_ptr_q) + i) % N);
      if (!pick_valid && req_if.req_stb[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;
    add_stb_d   = add_stb_q;
    add_z_ack_d = 1'b0;
    req_ack_d   = '0;
    rsp_z_d     = rsp_z_q;
    rsp_stb_d   = rsp_stb_q;
    op_done     = 1'b0;
    op_count_d  = op_count_q + 16'd1;

    case (state_q)
      S_IDLE: begin
        if (pick_valid) begin
          add_a_d   = lane_a[pick_idx];
          add_b_d   = lane_b[pick_idx];
          grant_d   = pick_idx;
          req_ack_d = N'(1) << pick_idx;
          add_stb_d = 1'b1;
          state_d   = S_ISSUE;
        end
      end
      // The adder has no input acks, so its strobes stay up until the sum returns.
      S_ISSUE: begin
        if (add_z_stb_i) begin
          rsp_z_d     = add_z_i;
          add_z_ack_d = 1'b1;
          add_stb_d   = 1'b0;
          rsp_stb_d   = N'(1) << grant_q;
          state_d     = S_RESP;
        end
      end
      S_RESP: begin
        if (req_if.rsp_ack[grant_q]) begin
          rsp_stb_d = '0;
          rr_ptr_d  = (grant_q == IW'(N - 1)) ? '0 : grant_q + 1'b1;
          op_done   = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // NOTE: rst is sampled only on the clock edge; it is the adder's reset too,
  // so an in-flight operation is dropped on both sides in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      add_stb_q   <= 1'b0;
      add_z_ack_q <= 1'b0;
      req_ack_q   <= '0;
      rsp_z_q     <= '0;
      rsp_stb_q   <= '0;
      busy_q      <= 1'b0;
      op_count_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      add_stb_q   <= add_stb_d;
      add_z_ack_q <= add_z_ack_d;
      req_ack_q   <= req_ack_d;
      rsp_z_q     <= rsp_z_d;
      rsp_stb_q   <= rsp_stb_d;
      busy_q      <= busy_d;
      if (op_done) op_count_q <= op_count_d;
    end
  end

  assign req_if.req_ack = req_ack_q;
  assign req_if.rsp_z   = rsp_z_q;
  assign req_if.rsp_stb = rsp_stb_q;
  assign add_a_o        = add_a_q;
  assign add_b_o        = add_b_q;
  assign add_a_stb_o    = add_stb_q;
  assign add_b_stb_o    = add_stb_q;
  assign add_z_ack_o    = add_z_ack_q;
  assign busy_o         = busy_q;
  assign grant_o        = grant_q;
  assign op_count_o     = op_count_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter with a table-driven adder stand-in;
// expected sums are hand-computed IEEE-754 single-precision constants.
module tb_adder_arbiter;

  localparam int N  = 4;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   add_a_o, add_b_o;
  logic          add_a_stb_o, add_b_stb_o;
  logic [31:0]   add_z;
  logic          add_z_stb;
  logic          add_z_ack_o;
  logic          busy_o;
  logic [IW-1:0] grant_o;
  logic [15:0]   op_count_o;

  adder_arbiter_if #(.N(N)) rif ();

  adder_arbiter #(.N(N), .IW(IW)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_if      (rif),
    .add_a_o     (add_a_o),
    .add_b_o     (add_b_o),
    .add_a_stb_o (add_a_stb_o),
    .add_b_stb_o (add_b_stb_o),
    .add_z_i     (add_z),
    .add_z_stb_i (add_z_stb),
    .add_z_ack_o (add_z_ack_o),
    .busy_o      (busy_o),
    .grant_o     (grant_o),
    .op_count_o  (op_count_o)
  );

  always #5 clk = ~clk;

  // Adder stand-in: knows only the operand pairs used below.
  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h3F800000, 32'h40000000}: return 32'h40400000;  // 1 + 2 = 3
      {32'h3F800000, 32'h3F800000}: return 32'h40000000;  // 1 + 1 = 2
      {32'h40400000, 32'hC0400000}: return 32'h00000000;  // 3 + -3 = 0
      {32'h40000000, 32'h40400000}: return 32'h40A00000;  // 2 + 3 = 5
      {32'h40000000, 32'h40000000}: return 32'h40800000;  // 2 + 2 = 4
      default:                      return 32'hDEADBEEF;
    endcase
  endfunction

  int          add_lat;
  int          m_cnt;
  logic        m_armed;
  logic [31:0] m_a, m_b;

  always @(posedge clk) begin
    if (rst) begin
      add_z_stb <= 1'b0;
      add_z     <= '0;
      m_cnt     <= 0;
      m_armed   <= 1'b1;
      m_a       <= '0;
      m_b       <= '0;
    end else begin
      if (!add_a_stb_o) m_armed <= 1'b1;
      if (m_armed && add_a_stb_o && add_b_stb_o && m_cnt == 0 && !add_z_stb) begin
        m_armed <= 1'b0;
        m_cnt   <= add_lat;
        m_a     <= add_a_o;
        m_b     <= add_b_o;
      end else if (m_cnt > 1) begin
        m_cnt <= m_cnt - 1;
      end else if (m_cnt == 1) begin
        m_cnt     <= 0;
        add_z_stb <= 1'b1;
        add_z     <= fadd(m_a, m_b);
      end
      if (add_z_stb && add_z_ack_o) add_z_stb <= 1'b0;
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
    rif.req_a[32*i +: 32] = a;
    rif.req_b[32*i +: 32] = b;
    rif.req_stb[i]        = 1'b1;
  endtask

  logic [N-1:0] last_rsp_stb;
  logic         last_zack;
  logic         last_astb;

  // Waits for a response; g is the one-hot lane index (-1 timeout, -2 not one-hot).
  task automatic serve(input bit keep_stb, input bit stop, input bit do_ack,
                       output int g, output logic [31:0] z);
    g = -1;
    z = '0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (!keep_stb) rif.req_stb = rif.req_stb & ~rif.req_ack;
      if (|rif.rsp_stb) begin
        g = -2;
        for (int i = 0; i < N; i++)
          if (rif.rsp_stb == (N'(1) << i)) g = i;
        z            = rif.rsp_z;
        last_rsp_stb = rif.rsp_stb;
        last_zack    = add_z_ack_o;
        last_astb    = add_a_stb_o;
        if (stop) rif.req_stb = '0;
        if (do_ack) begin
          rif.rsp_ack = rif.rsp_stb;
          @(negedge clk);
          rif.rsp_ack = '0;
        end
        return;
      end
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int          g;
    logic [31:0] z;
    logic [31:0] lane_z [N];
    lane_z[0] = 32'h40000000;
    lane_z[1] = 32'h40400000;
    lane_z[2] = 32'h00000000;
    lane_z[3] = 32'h40A00000;

    rif.req_a   = '0;
    rif.req_b   = '0;
    rif.req_stb = '0;
    rif.rsp_ack = '0;
    add_lat     = 2;
    rst         = 1'b1;
    repeat (2) @(negedge clk);

    // Reset values
    check("rst_busy", busy_o, 0);
    check("rst_grant", grant_o, 0);
    check("rst_opcnt", op_count_o, 0);
    check("rst_req_ack", rif.req_ack, 0);
    check("rst_rsp_stb", rif.rsp_stb, 0);
    check("rst_rsp_z", rif.rsp_z, 0);
    check("rst_add_a", add_a_o, 0);
    check("rst_add_b", add_b_o, 0);
    check("rst_stbs", {add_a_stb_o, add_b_stb_o, add_z_ack_o}, 0);
    rst = 1'b0;
    @(negedge clk);

    // Single op on requester 1
    set_req(1, 32'h3F800000, 32'h40000000);
    @(negedge clk);
    check("single_req_ack", rif.req_ack, 4'b0010);
    check("single_astb", {add_a_stb_o, add_b_stb_o}, 2'b11);
    check("single_add_a", add_a_o, 32'h3F800000);
    check("single_add_b", add_b_o, 32'h40000000);
    check("single_grant", grant_o, 1);
    check("single_busy", busy_o, 1);
    rif.req_stb = '0;
    @(negedge clk);
    check("single_ack_pulse", rif.req_ack, 0);
    check("single_astb_hold", add_a_stb_o, 1);
    serve(0, 0, 1, g, z);
    check("single_rsp_stb", last_rsp_stb, 4'b0010);
    check("single_rsp_z", z, 32'h40400000);
    check("single_zack", last_zack, 1);
    check("single_astb_drop", last_astb, 0);
    check("single_opcnt", op_count_o, 1);
    check("single_idle", busy_o, 0);

    // Contention 0 and 2 from reset, then rr_ptr probe with 0 and 3
    pulse_reset();
    set_req(0, 32'h3F800000, 32'h3F800000);
    set_req(2, 32'h40400000, 32'hC0400000);
    serve(0, 0, 1, g, z);
    check("cont_first_g", g, 0);
    check("cont_first_z", z, 32'h40000000);
    serve(0, 0, 1, g, z);
    check("cont_second_g", g, 2);
    check("cont_second_z", z, 32'h00000000);
    set_req(0, 32'h3F800000, 32'h3F800000);
    set_req(3, 32'h40000000, 32'h40400000);
    serve(0, 0, 1, g, z);
    check("rrptr3_g", g, 3);
    check("rrptr3_z", z, 32'h40A00000);
    serve(0, 0, 1, g, z);
    check("rrptr3_next_g", g, 0);
    check("cont_opcnt", op_count_o, 4);

    // Starvation: all four hold req_stb for 12 operations
    pulse_reset();
    set_req(0, 32'h3F800000, 32'h3F800000);
    set_req(1, 32'h3F800000, 32'h40000000);
    set_req(2, 32'h40400000, 32'hC0400000);
    set_req(3, 32'h40000000, 32'h40400000);
    for (int k = 0; k < 12; k++) begin
      serve(1, k == 11, 1, g, z);
      check($sformatf("starve%0d_g", k), g, k % N);
      check($sformatf("starve%0d_z", k), z, lane_z[k % N]);
    end
    check("starve_opcnt", op_count_o, 12);

    // Response back-pressure with a pending request and a stray ack
    set_req(2, 32'h40000000, 32'h40000000);
    serve(0, 0, 0, g, z);
    check("bp_g", g, 2);
    check("bp_z", z, 32'h40800000);
    set_req(1, 32'h3F800000, 32'h40000000);
    rif.rsp_ack = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("bp%0d_rsp_z", k), rif.rsp_z, 32'h40800000);
      check($sformatf("bp%0d_rsp_stb", k), rif.rsp_stb, 4'b0100);
      check($sformatf("bp%0d_req_ack", k), rif.req_ack, 0);
      check($sformatf("bp%0d_busy", k), busy_o, 1);
    end
    rif.rsp_ack = 4'b0100;
    @(negedge clk);
    rif.rsp_ack = '0;
    serve(0, 0, 1, g, z);
    check("bp_next_g", g, 1);
    check("bp_next_z", z, 32'h40400000);

    // Reset four cycles after grant while the adder is still working
    pulse_reset();
    check("midrst_pre_opcnt", op_count_o, 0);
    add_lat = 10;
    set_req(0, 32'h3F800000, 32'h3F800000);
    @(negedge clk);
    check("midrst_granted", rif.req_ack, 4'b0001);
    rif.req_stb = '0;
    repeat (3) @(negedge clk);
    check("midrst_in_issue", {busy_o, add_a_stb_o}, 2'b11);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", busy_o, 0);
    check("midrst_stbs", {add_a_stb_o, add_b_stb_o, add_z_ack_o}, 0);
    check("midrst_add_a", add_a_o, 0);
    check("midrst_add_b", add_b_o, 0);
    check("midrst_rsp", {rif.rsp_stb, rif.req_ack}, 0);
    check("midrst_grant", grant_o, 0);
    check("midrst_opcnt", op_count_o, 0);
    repeat (14) @(negedge clk);
    check("midrst_no_rsp", rif.rsp_stb, 0);
    check("midrst_still_idle", busy_o, 0);
    add_lat = 2;
    set_req(1, 32'h3F800000, 32'h40000000);
    serve(0, 0, 1, g, z);
    check("midrst_after_g", g, 1);
    check("midrst_after_z", z, 32'h40400000);
    check("midrst_after_opcnt", op_count_o, 1);

    // Counter wrap from a preloaded 0xFFFF
    force dut.op_count_q = 16'hFFFF;
    @(negedge clk);
    release dut.op_count_q;
    @(negedge clk);
    check("wrap_preload", op_count_o, 16'hFFFF);
    set_req(3, 32'h40000000, 32'h40400000);
    serve(0, 0, 1, g, z);
    check("wrap_g", g, 3);
    check("wrap_opcnt", op_count_o, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
